ysyx_23060236_mem_arbiter: RTL and testbench

Two-requester AXI4 arbiter that shares the single virtual-address master port in front of the MMU between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It serialises whole transactions, one outstanding at a time. It routes responses back only to the granted requester and latches bus errors. It sits between the core's IFU/LSU and the MMU's `v_io_master_*` port.

---
 rtl/ysyx_23060236_mem_arbiter_pkg.sv | 24 ++
 rtl/ysyx_23060236_mem_arbiter_rr_pick.sv | 16 +
 rtl/ysyx_23060236_mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_ysyx_23060236_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060236_mem_arbiter_pkg.sv
// Shared AXI bus definitions for the IFU/LSU memory arbiter: response codes,
// arbiter state encoding and requester identifiers.
package ysyx_23060236_bus_pkg;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != OKAY;
    endfunction

endpackage

// File: rtl/ysyx_23060236_mem_arbiter_rr_pick.sv
// Two-way round-robin picker: bit 0 is the IFU, bit 1 the LSU. On a tie the
// requester that did not win last time is granted.
module ysyx_23060236_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ysyx_23060236_mem_arbiter.sv
// Shares the MMU virtual-address AXI master between the IFU (read-only) and
// the LSU (read/write), one whole transaction at a time.
module ysyx_23060236_mem_arbiter
    import ysyx_23060236_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_arvalid,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [3:0]          ifu_arid,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    input  logic [1:0]          ifu_arburst,
    output logic                ifu_arready,
    output logic                ifu_rvalid,
    output logic [1:0]          ifu_rresp,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rlast,
    output logic [3:0]          ifu_rid,
    input  logic                ifu_rready,

    input  logic                lsu_arvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [3:0]          lsu_arid,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    input  logic [1:0]          lsu_arburst,
    output logic                lsu_arready,
    output logic                lsu_rvalid,
    output logic [1:0]          lsu_rresp,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rlast,
    output logic [3:0]          lsu_rid,
    input  logic                lsu_rready,
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [3:0]          lsu_awid,
    input  logic [7:0]          lsu_awlen,
    input  logic [2:0]          lsu_awsize,
    input  logic [1:0]          lsu_awburst,
    output logic                lsu_awready,
    input  logic                lsu_wvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    output logic                lsu_wready,
    output logic                lsu_bvalid,
    output logic [1:0]          lsu_bresp,
    output logic [3:0]          lsu_bid,
    input  logic                lsu_bready,

    output logic                m_arvalid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [3:0]          m_arid,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    input  logic                m_arready,
    input  logic                m_rvalid,
    input  logic [1:0]          m_rresp,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rlast,
    input  logic [3:0]          m_rid,
    output logic                m_rready,
    output logic                m_awvalid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [3:0]          m_awid,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    input  logic                m_awready,
    output logic                m_wvalid,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_wready,
    input  logic                m_bvalid,
    input  logic [1:0]          m_bresp,
    input  logic [3:0]          m_bid,
    output logic                m_bready,

    output logic                busy,
    output logic                bus_err,
    input  logic                err_clr
);

    arb_state_e state_q, state_d;
    req_id_e    last_q, last_d;
    req_id_e    owner_q, owner_d;
    logic       bus_err_q, bus_err_d;
    logic [1:0] req, gnt;
    logic       err_evt;

    assign req = {lsu_arvalid | lsu_awvalid, ifu_arvalid};

    ysyx_23060236_rr_pick u_pick (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= REQ_LSU;
            owner_q   <= REQ_IFU;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    last_d  = gnt[1] ? REQ_LSU : REQ_IFU;
                    owner_d = gnt[1] ? REQ_LSU : REQ_IFU;
                    state_d = (gnt[1] && lsu_awvalid) ? WR : RD;
                end
            end
            RD: if (m_rvalid && m_rready && m_rlast) state_d = IDLE;
            WR: if (m_bvalid && m_bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Readies are only ever raised toward the owner, so any handshake here is a delivered beat.
        err_evt   = (m_rvalid && m_rready && resp_is_err(m_rresp))
                  || (m_bvalid && m_bready && resp_is_err(m_bresp));
        bus_err_d = err_clr ? 1'b0 : (bus_err_q | err_evt);
    end

    always_comb begin
        m_araddr  = (owner_q == REQ_LSU) ? lsu_araddr  : ifu_araddr;
        m_arid    = (owner_q == REQ_LSU) ? lsu_arid    : ifu_arid;
        m_arlen   = (owner_q == REQ_LSU) ? lsu_arlen   : ifu_arlen;
        m_arsize  = (owner_q == REQ_LSU) ? lsu_arsize  : ifu_arsize;
        m_arburst = (owner_q == REQ_LSU) ? lsu_arburst : ifu_arburst;
        m_awaddr  = lsu_awaddr;
        m_awid    = lsu_awid;
        m_awlen   = lsu_awlen;
        m_awsize  = lsu_awsize;
        m_awburst = lsu_awburst;
        m_wdata   = lsu_wdata;
        m_wstrb   = lsu_wstrb;
        m_wlast   = lsu_wlast;
        ifu_rresp = m_rresp;
        ifu_rdata = m_rdata;
        ifu_rlast = m_rlast;
        ifu_rid   = m_rid;
        lsu_rresp = m_rresp;
        lsu_rdata = m_rdata;
        lsu_rlast = m_rlast;
        lsu_rid   = m_rid;
        lsu_bresp = m_bresp;
        lsu_bid   = m_bid;

        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;

        unique case (state_q)
            RD: begin
                if (owner_q == REQ_LSU) begin
                    m_arvalid   = lsu_arvalid;
                    lsu_arready = m_arready;
                    lsu_rvalid  = m_rvalid;
                    m_rready    = lsu_rready;
                end else begin
                    m_arvalid   = ifu_arvalid;
                    ifu_arready = m_arready;
                    ifu_rvalid  = m_rvalid;
                    m_rready    = ifu_rready;
                end
            end
            WR: begin
                m_awvalid   = lsu_awvalid;
                lsu_awready = m_awready;
                m_wvalid    = lsu_wvalid;
                lsu_wready  = m_wready;
                lsu_bvalid  = m_bvalid;
                m_bready    = lsu_bready;
            end
            default: ;
        endcase

        busy    = (state_q != IDLE);
        bus_err = bus_err_q;
    end

endmodule

// File: tb/tb_ysyx_23060236_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter with a transaction-level
// ownership model checked every cycle plus hand-computed expectations.
module tb_ysyx_23060236_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [3:0]  ifu_arid, ifu_rid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [3:0]  lsu_arid, lsu_rid;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_awid, lsu_wstrb, lsu_bid;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst, lsu_bresp;
    logic        lsu_bvalid, lsu_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
    logic [31:0] m_araddr, m_rdata;
    logic [3:0]  m_arid, m_rid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_awid, m_wstrb, m_bid;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst, m_bresp;
    logic        m_bvalid, m_bready;
    logic        busy, bus_err, err_clr;

    ysyx_23060236_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rresp(ifu_rresp),
        .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rresp(lsu_rresp),
        .lsu_rdata(lsu_rdata), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid),
        .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
        .lsu_awready(lsu_awready), .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid), .lsu_bready(lsu_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rresp(m_rresp), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .m_rid(m_rid), .m_rready(m_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid),
        .m_bready(m_bready),
        .busy(busy), .bus_err(bus_err), .err_clr(err_clr)
    );

    always #5 clock = ~clock;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endfunction

    // Ownership model: who holds the bus, who wins the next tie, sticky error.
    typedef enum int {H_NONE, H_IFU_RD, H_LSU_RD, H_LSU_WR} holder_t;
    holder_t holder = H_NONE;
    bit      tie_to_ifu = 1'b1;
    bit      err_m = 1'b0;
    bit      model_ok = 1'b0;

    always @(negedge clock) begin : compare
        logic        ri, rl, wr, e, want_i, want_l;
        logic [11:0] exp_v, got_v;
        ri = (holder == H_IFU_RD);
        rl = (holder == H_LSU_RD);
        wr = (holder == H_LSU_WR);
        if (model_ok) begin
            exp_v = {ri & m_arready, rl & m_arready, wr & m_awready, wr & m_wready,
                     (ri & ifu_arvalid) | (rl & lsu_arvalid), wr & lsu_awvalid, wr & lsu_wvalid,
                     ri & m_rvalid, rl & m_rvalid, wr & m_bvalid,
                     (ri & ifu_rready) | (rl & lsu_rready), wr & lsu_bready};
            got_v = {ifu_arready, lsu_arready, lsu_awready, lsu_wready,
                     m_arvalid, m_awvalid, m_wvalid,
                     ifu_rvalid, lsu_rvalid, lsu_bvalid, m_rready, m_bready};
            chk("valid_ready_routing", 32'(got_v), 32'(exp_v));
            chk("busy", 32'(busy), 32'(holder != H_NONE));
            chk("bus_err", 32'(bus_err), 32'(err_m));
            if (exp_v[7]) begin
                chk("m_araddr", m_araddr, ri ? ifu_araddr : lsu_araddr);
                chk("m_arlen", 32'(m_arlen), 32'(ri ? ifu_arlen : lsu_arlen));
            end
            if (exp_v[6]) chk("m_awaddr", m_awaddr, lsu_awaddr);
            if (exp_v[5]) chk("m_wdata", m_wdata, lsu_wdata);
            if (exp_v[4]) chk("ifu_rdata", ifu_rdata, m_rdata);
            if (exp_v[3]) chk("lsu_rdata", lsu_rdata, m_rdata);
            if (exp_v[2]) chk("lsu_bresp", 32'(lsu_bresp), 32'(m_bresp));
        end
        if (reset) begin
            holder     = H_NONE;
            tie_to_ifu = 1'b1;
            err_m      = 1'b0;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            e = ((ri & ifu_rready) | (rl & lsu_rready)) & m_rvalid & (m_rresp != 2'd0);
            e = e | (wr & m_bvalid & lsu_bready & (m_bresp != 2'd0));
            err_m = err_clr ? 1'b0 : (err_m | e);
            want_i = ifu_arvalid;
            want_l = lsu_arvalid | lsu_awvalid;
            case (holder)
                H_NONE: begin
                    if (want_i && (!want_l || tie_to_ifu)) begin
                        holder = H_IFU_RD;
                        tie_to_ifu = 1'b0;
                    end else if (want_l) begin
                        holder = lsu_awvalid ? H_LSU_WR : H_LSU_RD;
                        tie_to_ifu = 1'b1;
                    end
                end
                H_IFU_RD: if (m_rvalid && ifu_rready && m_rlast) holder = H_NONE;
                H_LSU_RD: if (m_rvalid && lsu_rready && m_rlast) holder = H_NONE;
                default:  if (m_bvalid && lsu_bready) holder = H_NONE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return m_arvalid;
            1:       return m_awvalid;
            2:       return m_rready;
            default: return lsu_bvalid;
        endcase
    endfunction

    task automatic wait_for(input int s, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (sig(s) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic grant_read(input logic [31:0] exp_addr, input logic [7:0] exp_len);
        bit was_ifu;
        wait_for(0, "wait_m_arvalid");
        chk("grant_addr", m_araddr, exp_addr);
        chk("grant_len", 32'(m_arlen), 32'(exp_len));
        was_ifu = ifu_arready;
        tick();
        if (was_ifu) ifu_arvalid = 1'b0;
        else lsu_arvalid = 1'b0;
    endtask

    task automatic rd_beats(input int n, input logic [31:0] base, input logic [1:0] resp);
        for (int b = 0; b < n; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(b);
            m_rresp  = resp;
            m_rlast  = (b == n - 1);
            wait_for(2, "wait_m_rready");
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'd0;
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        lsu_awvalid = 1'b1; lsu_awaddr = a;
        lsu_wvalid = 1'b1; lsu_wdata = d; lsu_wstrb = 4'hF; lsu_wlast = 1'b1;
        wait_for(1, "wait_m_awvalid");
        tick();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        m_bvalid = 1'b1; m_bresp = resp;
        wait_for(3, "wait_lsu_bvalid");
        tick();
        m_bvalid = 1'b0; m_bresp = 2'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ifu_arvalid = 0; ifu_araddr = 0; ifu_arid = 4'd0; ifu_arlen = 0; ifu_arsize = 3'd2;
        ifu_arburst = 2'd1; ifu_rready = 1;
        lsu_arvalid = 0; lsu_araddr = 0; lsu_arid = 4'd1; lsu_arlen = 0; lsu_arsize = 3'd2;
        lsu_arburst = 2'd1; lsu_rready = 1;
        lsu_awvalid = 0; lsu_awaddr = 0; lsu_awid = 4'd1; lsu_awlen = 0; lsu_awsize = 3'd2;
        lsu_awburst = 2'd1; lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 0;
        lsu_bready = 1;
        m_arready = 1; m_awready = 1; m_wready = 1;
        m_rvalid = 0; m_rresp = 0; m_rdata = 0; m_rlast = 0; m_rid = 0;
        m_bvalid = 0; m_bresp = 0; m_bid = 0;
        err_clr = 0;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state, then single IFU read with one cycle of arbitration latency
        @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
        tick();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd0;
        @(negedge clock);
        chk("ar_held_in_idle", 32'(m_arvalid), 32'd0);
        tick();
        @(negedge clock);
        chk("ar_fwd_n_plus_1", 32'(m_arvalid), 32'd1);
        chk("ar_fwd_addr", m_araddr, 32'h8000_0000);
        chk("busy_granted", 32'(busy), 32'd1);
        tick();
        ifu_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h0000_1234; m_rlast = 1'b1;
        @(negedge clock);
        chk("ifu_rvalid", 32'(ifu_rvalid), 32'd1);
        chk("ifu_rdata", ifu_rdata, 32'h0000_1234);
        chk("lsu_rvalid_quiet", 32'(lsu_rvalid), 32'd0);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clock);
        chk("busy_after_rlast", 32'(busy), 32'd0);

        // Tie after reset: IFU, then LSU on the repeat tie, then IFU
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_1000;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000; lsu_arlen = 8'd0;
        grant_read(32'h8000_1000, 8'd0);
        rd_beats(1, 32'h1111_0000, 2'd0);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_3000;
        grant_read(32'h8000_2000, 8'd0);
        rd_beats(1, 32'h2222_0000, 2'd0);
        grant_read(32'h8000_3000, 8'd0);
        rd_beats(1, 32'h3333_0000, 2'd0);

        // LSU write with W presented before AW; IFU contends while it runs
        lsu_wvalid = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wlast = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("w_held_in_idle", 32'(m_wvalid), 32'd0);
            chk("wready_in_idle", 32'(lsu_wready), 32'd0);
            tick();
        end
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0100;
        wait_for(1, "wait_m_awvalid");
        chk("wr_awaddr", m_awaddr, 32'h8000_0100);
        chk("wr_wvalid", 32'(m_wvalid), 32'd1);
        chk("wr_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", 32'(m_wstrb), 32'hF);
        tick();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_4000;
        m_bvalid = 1'b1; m_bresp = 2'd0;
        wait_for(3, "wait_lsu_bvalid");
        chk("ifu_arready_blocked", 32'(ifu_arready), 32'd0);
        chk("m_arvalid_blocked", 32'(m_arvalid), 32'd0);
        tick();
        m_bvalid = 1'b0;
        grant_read(32'h8000_4000, 8'd0);
        rd_beats(1, 32'h4444_0000, 2'd0);

        // LSU burst of four beats; ownership held until the rlast beat
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0200; lsu_arlen = 8'd3;
        grant_read(32'h8000_0200, 8'd3);
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1; m_rdata = 32'h0000_00A0 + 32'(b); m_rlast = (b == 3);
            @(negedge clock);
            chk("burst_lsu_rvalid", 32'(lsu_rvalid), 32'd1);
            chk("burst_lsu_rdata", lsu_rdata, 32'h0000_00A0 + 32'(b));
            chk("burst_busy", 32'(busy), 32'd1);
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clock);
        chk("burst_done_busy", 32'(busy), 32'd0);
        lsu_arlen = 8'd0;

        // Sticky error, clear, and clear winning over a simultaneous error
        tick();
        write_txn(32'h8000_0300, 32'h0000_0055, 2'd2);
        @(negedge clock);
        chk("bresp_err_set", 32'(bus_err), 32'd1);
        tick(); tick();
        @(negedge clock);
        chk("bus_err_sticky", 32'(bus_err), 32'd1);
        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        @(negedge clock);
        chk("err_clr", 32'(bus_err), 32'd0);
        tick();
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0400;
        grant_read(32'h8000_0400, 8'd0);
        m_rvalid = 1'b1; m_rresp = 2'd2; m_rlast = 1'b1; err_clr = 1'b1;
        tick();
        m_rvalid = 1'b0; m_rresp = 2'd0; m_rlast = 1'b0; err_clr = 1'b0;
        @(negedge clock);
        chk("clr_beats_set", 32'(bus_err), 32'd0);
        tick();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0500;
        grant_read(32'h8000_0500, 8'd0);
        rd_beats(1, 32'h5555_0000, 2'd3);
        @(negedge clock);
        chk("rresp_err_set", 32'(bus_err), 32'd1);
        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0;

        // Reset in the middle of a two-beat read, then a fresh IFU read
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_5000; ifu_arlen = 8'd1;
        grant_read(32'h8000_5000, 8'd1);
        m_rvalid = 1'b1; m_rdata = 32'h0000_5A5A; m_rlast = 1'b0;
        @(negedge clock);
        chk("mid_rd_beat", 32'(ifu_rvalid), 32'd1);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rvalid_dropped", 32'(ifu_rvalid), 32'd0);
        chk("rst_mid_m_rready", 32'(m_rready), 32'd0);
        chk("rst_mid_m_arvalid", 32'(m_arvalid), 32'd0);
        tick();
        m_rvalid = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_6000; ifu_arlen = 8'd0;
        grant_read(32'h8000_6000, 8'd0);
        rd_beats(1, 32'h6666_0000, 2'd0);
        @(negedge clock);
        chk("post_reset_idle", 32'(busy), 32'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
